// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared types for the hazard/forwarding controller: FSM state,
//               scoreboard entry and the register-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // Widest register address the scoreboard can hold; narrower files zero-extend.
    localparam int c_SB_RD_W = 8;

    localparam logic [c_SB_RD_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic                 valid;
        logic [c_SB_RD_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } sb_entry_t;

    localparam sb_entry_t c_SB_EMPTY = '0;

    function automatic logic sb_hit(
        input sb_entry_t            e,
        input logic [c_SB_RD_W-1:0] src,
        input logic                 uses
    );
        return e.valid && e.reg_write && (e.rd == src) && (src != REG_ZERO) && uses;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_match
// Description : Compares one source register against the EX/MEM/WB scoreboard
//               slots; returns a nearest-producer one-hot select and load hit.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_match
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [c_SB_RD_W-1:0] i_src,
    input  logic                 i_uses,
    input  sb_entry_t            i_slot0,
    input  sb_entry_t            i_slot1,
    input  sb_entry_t            i_slot2,
    output logic [2:0]           o_sel,       // {ex, mem, wb}
    output logic                 o_load_hit
);

    logic w_hit0;
    logic w_hit1;
    logic w_hit2;
    logic w_unused;

    assign w_hit0 = sb_hit(i_slot0, i_src, i_uses);
    assign w_hit1 = sb_hit(i_slot1, i_src, i_uses);
    assign w_hit2 = sb_hit(i_slot2, i_src, i_uses);

    assign o_sel      = {w_hit0, ~w_hit0 & w_hit1, ~w_hit0 & ~w_hit1 & w_hit2};
    // Only a load still in EX cannot be forwarded; older loads have their data.
    assign o_load_hit = w_hit0 & i_slot0.mem_read;

    assign w_unused = &{1'b0, i_slot1.mem_read, i_slot2.mem_read};

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard/forwarding controller for the 5-stage MIPS-lite pipe:
//               scoreboard, forward selects, stalls, flush and halt drain.
//               Macro HAZARD_FORWARDING_EN enables operand forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 3
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_halt,
    input  logic              branch_taken,
    output logic              stall_o,
    output logic              bubble_o,
    output logic              flush_o,
    output logic              Forward_1,
    output logic              Forward_2,
    output logic              mem_Forward_1,
    output logic              mem_Forward_2,
    output logic              wb_Forward_1,
    output logic              wb_Forward_2,
    output logic              halted_o,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int                  c_DCNT_W     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [c_DCNT_W-1:0] c_DRAIN_LAST = c_DCNT_W'(DRAIN_CYC - 1);

    sb_entry_t            r_slot0;
    sb_entry_t            r_slot1;
    sb_entry_t            r_slot2;
    hz_state_e            r_state;
    logic [c_DCNT_W-1:0]  r_dcnt;
    logic [2:0]           r_fwd1;
    logic [2:0]           r_fwd2;
    logic                 r_halted;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic [c_SB_RD_W-1:0] w_rs;
    logic [c_SB_RD_W-1:0] w_rt;
    logic [c_SB_RD_W-1:0] w_rd;
    logic [2:0]           w_sel_rs;
    logic [2:0]           w_sel_rt;
    logic                 w_load_rs;
    logic                 w_load_rt;
    logic [2:0]           w_fwd_rs;
    logic [2:0]           w_fwd_rt;
    logic                 w_hazard;
    logic                 w_stall;
    logic                 w_bubble;
    logic                 w_issue;
    logic                 w_halt_issue;
    logic                 w_slot0_load;

    assign w_rs = c_SB_RD_W'(id_rs);
    assign w_rt = c_SB_RD_W'(id_rt);
    assign w_rd = c_SB_RD_W'(id_rd);

    hazard_match u_match_rs (
        .i_src      (w_rs),
        .i_uses     (id_uses_rs),
        .i_slot0    (r_slot0),
        .i_slot1    (r_slot1),
        .i_slot2    (r_slot2),
        .o_sel      (w_sel_rs),
        .o_load_hit (w_load_rs)
    );

    hazard_match u_match_rt (
        .i_src      (w_rt),
        .i_uses     (id_uses_rt),
        .i_slot0    (r_slot0),
        .i_slot1    (r_slot1),
        .i_slot2    (r_slot2),
        .o_sel      (w_sel_rt),
        .o_load_hit (w_load_rt)
    );

`ifdef HAZARD_FORWARDING_EN
    assign w_hazard = w_load_rs | w_load_rt;
    assign w_fwd_rs = w_sel_rs;
    assign w_fwd_rt = w_sel_rt;
`else
    // Without forwarding every in-flight producer blocks; a load hit is a subset.
    assign w_hazard = (|w_sel_rs) | (|w_sel_rt) | w_load_rs | w_load_rt;
    assign w_fwd_rs = 3'b000;
    assign w_fwd_rt = 3'b000;
`endif

    always_comb begin
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        case (r_state)
            RUN: begin
                if (!branch_taken && id_valid && w_hazard) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
            end
            DRAIN:   w_stall = ~branch_taken;
            HALTED:  w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    assign w_issue      = (r_state == RUN) && id_valid && !w_stall && !branch_taken;
    assign w_halt_issue = w_issue && id_halt;
    // A halt moves down the pipe as a bubble.
    assign w_slot0_load = w_issue && !id_halt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot0 <= c_SB_EMPTY;
            r_slot1 <= c_SB_EMPTY;
            r_slot2 <= c_SB_EMPTY;
            r_fwd1  <= 3'b000;
            r_fwd2  <= 3'b000;
        end else begin
            r_slot2 <= r_slot1;
            r_slot1 <= r_slot0;
            if (w_slot0_load) begin
                r_slot0 <= '{valid: 1'b1, rd: w_rd, reg_write: id_reg_write, mem_read: id_mem_read};
                r_fwd1  <= w_fwd_rs;
                r_fwd2  <= w_fwd_rt;
            end else begin
                r_slot0 <= c_SB_EMPTY;
                r_fwd1  <= 3'b000;
                r_fwd2  <= 3'b000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_dcnt      <= '0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_halt_issue) begin
                        r_state <= DRAIN;
                        r_dcnt  <= '0;
                    end
                    if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
                DRAIN: begin
                    // A taken branch means the halt was on the wrong path.
                    if (branch_taken) begin
                        r_state <= RUN;
                        r_dcnt  <= '0;
                    end else if (r_dcnt == c_DRAIN_LAST) begin
                        r_state  <= HALTED;
                        r_halted <= 1'b1;
                        r_dcnt   <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + c_DCNT_W'(1);
                    end
                end
                HALTED:  r_halted <= 1'b1;
                default: r_state  <= RUN;
            endcase
        end
    end

    assign stall_o       = w_stall;
    assign bubble_o      = w_bubble;
    assign flush_o       = branch_taken;
    assign Forward_1     = r_fwd1[2];
    assign mem_Forward_1 = r_fwd1[1];
    assign wb_Forward_1  = r_fwd1[0];
    assign Forward_2     = r_fwd2[2];
    assign mem_Forward_2 = r_fwd2[1];
    assign wb_Forward_2  = r_fwd2[0];
    assign halted_o      = r_halted;
    assign stall_count   = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS-lite pipeline; sequences the execute-stage datapath.
- Tracks in-flight destination registers in a 3-entry scoreboard covering EX, MEM and WB.
- Drives the registered forwarding selects Forward_1/2, mem_Forward_1/2 and wb_Forward_1/2 into Execute.
- Generates load-use stalls, bubbles, branch flushes and halt drain; counts stall cycles.

Parameters:
REG_AW, 5, register address width
CNT_W, 32, stall counter width
DRAIN_CYC, 3, cycles to drain the pipeline after a halt issues

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, active-low, synchronous
id_valid  in  1  ID holds a valid instruction
id_rs  in  REG_AW  source 1 register
id_rt  in  REG_AW  source 2 register
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt (register operand)
id_rd  in  REG_AW  destination register
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
id_halt  in  1  instruction is HALT
branch_taken  in  1  from Execute, combinational, current cycle
stall_o  out  1  hold PC and IF/ID
bubble_o  out  1  insert NOP into ID/EX
flush_o  out  1  squash IF/ID and ID/EX
Forward_1, Forward_2  out  1 each  select EX/MEM aluOut
mem_Forward_1, mem_Forward_2  out  1 each  select mem_data_o
wb_Forward_1, wb_Forward_2  out  1 each  select wb_data
halted_o  out  1  pipeline drained after HALT
stall_count  out  CNT_W  saturating stall-cycle count

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: all outputs 0, all scoreboard slots invalid, FSM in RUN, drain counter 0, stall_count 0.
- Scoreboard slots: slot0 = instruction in EX, slot1 = MEM, slot2 = WB. Each slot holds {valid, rd, reg_write, mem_read}.
- Scoreboard update on each edge:
  - slot2<=slot1 and slot1<=slot0, always.
  - slot0<=ID instruction if id_valid, !stall_o and !flush_o; otherwise slot0<=invalid.
- Match rule: a match against a source requires slot valid, reg_write, rd==src, src!=0, and the matching id_uses_* set.
- Forward selects for each operand are computed in ID, registered on the edge, and aligned with the instruction entering EX.
  - slot0 match -> Forward_x.
  - else slot1 match -> mem_Forward_x.
  - else slot2 match -> wb_Forward_x.
  - Nearest producer wins; at most one select per operand is 1.
  - Selects are cleared on any cycle where slot0 loads invalid (bubble or flush).
- Load-use: a slot0 match with mem_read set gives stall_o=1 and bubble_o=1 for exactly 1 cycle. Next cycle the load is in slot1, so mem_Forward_x=1.
- Branch: flush_o=branch_taken.
  - Flush beats stall: stall_o and bubble_o are forced 0.
  - slot0 loads invalid.
  - id_halt is ignored that cycle.
- FSM states and transitions:
  - RUN -> DRAIN when id_halt issues (id_valid, !stall, !flush). The halt enters slot0 as a bubble.
  - DRAIN: stall_o=1; counter runs DRAIN_CYC cycles, then -> HALTED.
  - DRAIN -> RUN if branch_taken during DRAIN (wrong-path halt); the counter is cleared.
  - HALTED: stall_o=1, halted_o=1; leaves only on reset.
- stall_count increments in RUN when stall_o=1 and saturates at all-ones. It does not count in DRAIN or HALTED.
- Reset mid-stall or mid-drain: returns to RUN with an empty scoreboard on the next edge.

Optional Feature:
HAZARD_FORWARDING_EN
- Defined: forwarding as above; only load-use stalls.
- Undefined: all six forward outputs are tied 0. stall_o=bubble_o=1 while any slot0..slot2 match exists, giving up to 3 stall cycles per dependence. Flush priority and the FSM are unchanged.

Decomposition:
- Add to the TYPES package: hz_state_e {RUN, DRAIN, HALTED}, sb_entry_t struct, REG_ZERO constant.
- Sub-module hazard_match: one source register against 3 slots, producing a one-hot {ex, mem, wb} select plus load_hit. It is instantiated twice, once for rs and once for rt.

Test Plan:
- add r3,r1,r2 then sub r4,r3,r5 -> next cycle Forward_1=1 only; no stall; stall_count stays 0.
- lw r3 then add r4,r3,r3 -> stall_o=bubble_o=1 for 1 cycle, then mem_Forward_1=mem_Forward_2=1; stall_count=1.
- Producer r3, two independent instructions, then consumer of r3 -> wb_Forward_1=1; writer to r0 followed by reader of r0 -> all selects 0.
- Taken beq with a load-use pending in ID -> flush_o=1, stall_o=0, next-cycle selects 0.
- HALT issue -> stall_o=1 for 3 cycles, then halted_o=1. Repeat with branch_taken on the 2nd drain cycle -> back in RUN with halted_o=0.
- HAZARD_FORWARDING_EN undefined, add r3 then sub using r3 -> 3 stall cycles, forwards 0; reset asserted mid-stall -> all outputs 0 next edge.
